// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/LSU memory arbiter: controller states and requester ids.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin grant selection between fetch and LSU, with its last-granted pointer.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic if_req_i,
  input  logic lsu_req_i,
  output logic if_gnt_o,
  output logic lsu_gnt_o
);

  req_id_e last_r;

  // Winner selection: a tie goes to whichever side was not served last
  always_comb begin
    if_gnt_o  = 1'b0;
    lsu_gnt_o = 1'b0;
    if (en_i) begin
      if (if_req_i && lsu_req_i) begin
        if (last_r == REQ_LSU) begin
          if_gnt_o = 1'b1;
        end else begin
          lsu_gnt_o = 1'b1;
        end
      end else begin
        if_gnt_o  = if_req_i;
        lsu_gnt_o = lsu_req_i;
      end
    end else begin
      if_gnt_o  = 1'b0;
      lsu_gnt_o = 1'b0;
    end
  end

  // Last-granted pointer, reset so the LSU wins the first tie
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_r <= REQ_IF;
    end else if (if_gnt_o) begin
      last_r <= REQ_IF;
    end else if (lsu_gnt_o) begin
      last_r <= REQ_LSU;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one dual-port memory between instruction fetch and a load/store unit;
// partial-word stores are done as read, byte-merge, then write one cycle later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               if_req_i,
  input  logic [DEPTH-1:0]   if_addr_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [WIDTH-1:0]   if_rdata_o,
  input  logic               lsu_req_i,
  input  logic               lsu_we_i,
  input  logic [WIDTH/8-1:0] lsu_be_i,
  input  logic [DEPTH-1:0]   lsu_addr_i,
  input  logic [WIDTH-1:0]   lsu_wdata_i,
  output logic               lsu_gnt_o,
  output logic               lsu_rvalid_o,
  output logic [WIDTH-1:0]   lsu_rdata_o,
  output logic               mem_we_o,
  output logic [WIDTH-1:0]   mem_write_data_o,
  output logic [DEPTH-1:0]   mem_write_addr_o,
  output logic [DEPTH-1:0]   mem_read_addr_o,
  input  logic [WIDTH-1:0]   mem_read_data_i
);

  localparam int NB = WIDTH / 8;

  state_e           state_r, state_nxt_s;
  logic             arb_en_s, if_gnt_s, lsu_gnt_s;
  logic             full_store_s, part_store_s;
  logic [WIDTH-1:0] merged_s, merged_r, old_r;
  logic [DEPTH-1:0] addr_r;
  logic             if_rvalid_r, lsu_rvalid_r;
  logic [WIDTH-1:0] if_rdata_r, lsu_rdata_r;

  assign arb_en_s     = rst_ni && (state_r == IDLE);
  assign full_store_s = lsu_we_i && (&lsu_be_i);
  assign part_store_s = lsu_we_i && (|lsu_be_i) && !(&lsu_be_i);

  mem_arb_rr u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (arb_en_s),
    .if_req_i  (if_req_i),
    .lsu_req_i (lsu_req_i),
    .if_gnt_o  (if_gnt_s),
    .lsu_gnt_o (lsu_gnt_s)
  );

  assign if_gnt_o     = if_gnt_s;
  assign lsu_gnt_o    = lsu_gnt_s;
  assign if_rvalid_o  = if_rvalid_r;
  assign if_rdata_o   = if_rdata_r;
  assign lsu_rvalid_o = lsu_rvalid_r;
  assign lsu_rdata_o  = lsu_rdata_r;

  // Byte merge: enabled lanes from the store data, the rest from the current word
  always_comb begin
    merged_s = mem_read_data_i;
    for (int b = 0; b < NB; b++) begin
      if (lsu_be_i[b]) begin
        merged_s[8*b +: 8] = lsu_wdata_i[8*b +: 8];
      end else begin
        merged_s[8*b +: 8] = mem_read_data_i[8*b +: 8];
      end
    end
  end

  // Next state and memory port drive; writes are masked while reset is asserted
  always_comb begin
    state_nxt_s      = state_r;
    mem_we_o         = 1'b0;
    mem_write_addr_o = {DEPTH{1'b0}};
    mem_write_data_o = {WIDTH{1'b0}};
    mem_read_addr_o  = {DEPTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (if_gnt_s) begin
          mem_read_addr_o = if_addr_i;
        end else if (lsu_gnt_s) begin
          mem_read_addr_o = lsu_addr_i;
          if (full_store_s) begin
            mem_we_o         = 1'b1;
            mem_write_addr_o = lsu_addr_i;
            mem_write_data_o = lsu_wdata_i;
          end else if (part_store_s) begin
            state_nxt_s = RMW;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RMW: begin
        mem_we_o         = rst_ni;
        mem_write_addr_o = addr_r;
        mem_write_data_o = merged_r;
        state_nxt_s      = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, RMW holding registers and one-cycle read responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      merged_r     <= {WIDTH{1'b0}};
      old_r        <= {WIDTH{1'b0}};
      addr_r       <= {DEPTH{1'b0}};
      if_rvalid_r  <= 1'b0;
      if_rdata_r   <= {WIDTH{1'b0}};
      lsu_rvalid_r <= 1'b0;
      lsu_rdata_r  <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      if_rvalid_r <= if_gnt_s;
      if_rdata_r  <= if_gnt_s ? mem_read_data_i : {WIDTH{1'b0}};
      if (lsu_gnt_s && part_store_s) begin
        merged_r <= merged_s;
        old_r    <= mem_read_data_i;
        addr_r   <= lsu_addr_i;
      end
      // A partial store answers after its write cycle with the word captured at grant
      if (state_r == RMW) begin
        lsu_rvalid_r <= 1'b1;
        lsu_rdata_r  <= old_r;
      end else if (lsu_gnt_s && !part_store_s) begin
        lsu_rvalid_r <= 1'b1;
        lsu_rdata_r  <= mem_read_data_i;
      end else begin
        lsu_rvalid_r <= 1'b0;
        lsu_rdata_r  <= {WIDTH{1'b0}};
      end
    end
  end

endmodule
